// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time, holds
// the returned word for the decode/execute stage until it retires, then
// advances the pc (sequential or ALU target). A misaligned target halts the
// unit with a sticky error flag until the next reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        PCsel,
    input  logic [31:0] alu_out,
    output logic        misalign_err,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ir;
    logic [31:0] next_pc;
    logic        retire;
    logic        misalign;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Next-state, retirement decision and the request/valid outputs; the
    // outputs are gated by rst_n so a pending synchronous reset already
    // silences the memory request and the decode stage.
    always_comb begin
        state_nxt  = state;
        retire     = 1'b0;
        misalign   = 1'b0;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        inst       = NOP_INST;
        // Jump targets always have bit 0 cleared (JALR semantics).
        next_pc    = PCsel ? (alu_out & 32'hFFFF_FFFE) : pc_plus4;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = rst_n;
                if (imem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                inst_valid = rst_n;
                if (rst_n) begin
                    inst = ir;
                end
                if (exec_done) begin
                    retire    = 1'b1;
                    misalign  = (next_pc[1:0] != 2'b00);
                    state_nxt = misalign ? ERR : REQ;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // State, pc, instruction register, retire counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ir           <= NOP_INST;
            instret      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == REQ && imem_ack) begin
                ir <= imem_rdata;
            end
            if (retire) begin
                instret <= instret + 32'd1;
                if (misalign) begin
                    misalign_err <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done = 1'b0;
    logic        PCsel = 1'b0;
    logic [31:0] alu_out = 32'd0;
    logic        misalign_err;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int req_age = 0;
    int lat = 1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .exec_done    (exec_done),
        .PCsel        (PCsel),
        .alu_out      (alu_out),
        .misalign_err (misalign_err),
        .instret      (instret)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the fetch unit has been asked to do.
    bit          m_known = 1'b0;
    bit          m_boot, m_fetch, m_hold, m_halt, m_err;
    logic [31:0] m_pc, m_ir, m_instret;

    always @(posedge clk) begin : model
        logic [31:0] tgt;
        if (!rst_n) begin
            m_known   = 1'b1;
            m_boot    = 1'b1;
            m_fetch   = 1'b0;
            m_hold    = 1'b0;
            m_halt    = 1'b0;
            m_err     = 1'b0;
            m_pc      = RST_PC;
            m_ir      = NOP;
            m_instret = 32'd0;
        end else if (m_known) begin
            if (m_boot) begin
                m_boot  = 1'b0;
                m_fetch = 1'b1;
            end else if (m_fetch) begin
                if (imem_ack) begin
                    m_ir    = imem_rdata;
                    m_fetch = 1'b0;
                    m_hold  = 1'b1;
                end
            end else if (m_hold && exec_done) begin
                tgt       = PCsel ? (alu_out / 2) * 2 : m_pc + 32'd4;
                m_instret = m_instret + 32'd1;
                m_hold    = 1'b0;
                if (tgt % 4 != 0) begin
                    m_err  = 1'b1;
                    m_halt = 1'b1;
                end else begin
                    m_pc    = tgt;
                    m_fetch = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_known) begin
            check1 ("req",      imem_req,     rst_n && m_fetch);
            check32("addr",     imem_addr,    m_pc);
            check1 ("valid",    inst_valid,   rst_n && m_hold);
            check32("inst",     inst,         (rst_n && m_hold) ? m_ir : NOP);
            check32("pc",       pc,           m_pc);
            check32("pc_plus4", pc_plus4,     m_pc + 32'd4);
            check1 ("misalign", misalign_err, m_err);
            check32("instret",  instret,      m_instret);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: acknowledges `lat` cycles after the request appears.
    task automatic drive_mem();
        if (imem_req) req_age++;
        else req_age = 0;
        imem_ack = imem_req && (req_age > lat);
    endtask

    initial begin
        lat = 1; exec_done = 1'b1; PCsel = 1'b0; alu_out = 32'd0;
        imem_rdata = 32'h00A0_0093; rst_n = 1'b0; imem_ack = 1'b0;
        tick(); tick();
        check1 ("rst_req",     imem_req,     1'b0);
        check1 ("rst_valid",   inst_valid,   1'b0);
        check32("rst_inst",    inst,         NOP);
        check32("rst_pc",      pc,           32'h0);
        check32("rst_instret", instret,      32'h0);
        check1 ("rst_err",     misalign_err, 1'b0);

        // Back-to-back fetch, latency 1, immediate retire.
        rst_n = 1'b1; req_age = 0; drive_mem();
        for (int t = 1; t <= 9; t++) begin
            tick();
            check1("a_valid", inst_valid, (t % 3 == 0));
            if (t % 3 == 1) begin
                check1 ("a_req",  imem_req,  1'b1);
                check32("a_addr", imem_addr, 32'(t / 3) * 32'd4);
            end
            if (t % 3 == 0) check32("a_inst", inst, 32'h00A0_0093);
            drive_mem();
        end
        tick();
        check32("a_instret", instret, 32'd3);
        check32("a_addr12",  imem_addr, 32'hC);

        // Latency 4: request held with constant address, inst stays NOP.
        lat = 4; drive_mem();
        check1("b_req0", imem_req, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check1 ("b_req",   imem_req,   1'b1);
            check32("b_addr",  imem_addr,  32'hC);
            check1 ("b_valid", inst_valid, 1'b0);
            check32("b_inst",  inst,       NOP);
            drive_mem();
        end
        tick();
        imem_rdata = 32'h0010_0113; drive_mem();
        tick();
        check1 ("b_hvalid", inst_valid, 1'b1);
        check32("b_hinst",  inst,       32'h0010_0113);
        lat = 1; drive_mem();
        tick(); drive_mem();
        tick(); drive_mem();
        tick();
        check32("c_pc10", pc, 32'h10);
        PCsel = 1'b1; alu_out = 32'h0000_0041; drive_mem();
        tick();
        check32("c_tgt40", imem_addr, 32'h40);
        PCsel = 1'b0; drive_mem();
        tick(); drive_mem();
        tick();
        check32("c_pp4", pc_plus4, 32'h44);

        // Misaligned target halts the unit.
        PCsel = 1'b1; alu_out = 32'h0000_0102; drive_mem();
        tick();
        check1 ("e_err",     misalign_err, 1'b1);
        check32("e_pc",      pc,           32'h40);
        check32("e_instret", instret,      32'd6);
        check32("e_model",   m_instret,    32'd6);
        PCsel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1;
            tick();
            check1("e_noreq", imem_req, 1'b0);
            check1("e_still", misalign_err, 1'b1);
        end
        rst_n = 1'b0; imem_ack = 1'b0;
        tick();
        check32("e_rstpc", pc, RST_PC);
        check1 ("e_clr",   misalign_err, 1'b0);

        // Reset mid-request, then a stray ack in the IDLE cycle.
        rst_n = 1'b1;
        tick();
        check1("f_req", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("f_gate", imem_req, 1'b0);
        tick();
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check1 ("f_req2", imem_req,  1'b1);
        check32("f_addr", imem_addr, RST_PC);
        check32("f_nop",  inst,      NOP);
        imem_rdata = 32'h1111_1111; req_age = 0; drive_mem();
        tick(); drive_mem();
        tick();
        check32("f_inst", inst, 32'h1111_1111);

        // Wrap from the top of the address space.
        PCsel = 1'b1; alu_out = 32'hFFFF_FFFD; drive_mem();
        tick();
        check32("g_top", imem_addr, 32'hFFFF_FFFC);
        PCsel = 1'b0; drive_mem();
        tick(); drive_mem();
        tick();
        check32("g_pp4", pc_plus4, 32'h0);
        drive_mem();
        tick();
        check32("g_wrap", imem_addr, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (imem_req) req_age++;
            else begin
                req_age = 0;
                lat = int'($urandom_range(4, 1));
            end
            imem_ack   = imem_req ? (req_age > lat) : ($urandom_range(7) == 0);
            rst_n      = ($urandom_range(99) != 0);
            imem_rdata = $urandom;
            exec_done  = ($urandom_range(1) == 1);
            PCsel      = ($urandom_range(1) == 1);
            alu_out    = ($urandom & 32'hFFFF_FFFC) |
                         (($urandom_range(15) == 0) ? 32'($urandom_range(3, 1)) : 32'd0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
